// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// The sub signal exists only when SERIAL_ADD_CTRL_SUB_EN is defined.
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport slave (
`ifdef SERIAL_ADD_CTRL_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

    modport master (
`ifdef SERIAL_ADD_CTRL_SUB_EN
        output sub,
`endif
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder built from two half-adder stages and an OR.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic co_o
);
    logic ha0_s, ha0_c, ha1_c;

    assign ha0_s = a_i ^ b_i;
    assign ha0_c = a_i & b_i;
    assign s_o   = ha0_s ^ cin_i;
    assign ha1_c = ha0_s & cin_i;
    assign co_o  = ha0_c | ha1_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared fa_cell, one bit per clock, LSB first.
// Define SERIAL_ADD_CTRL_SUB_EN to add the sub input (a - b via ~b and carry-in 1).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("serial_add_ctrl: WIDTH out of range 2..32");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fa_s, fa_co;
    logic             ld_sub;

`ifdef SERIAL_ADD_CTRL_SUB_EN
    assign ld_sub = bus.sub;
`else
    assign ld_sub = 1'b0;
`endif

    fa_cell u_fa (
        .a_i   (a_sh_q[0]),
        .b_i   (b_sh_q[0]),
        .cin_i (carry_q),
        .s_o   (fa_s),
        .co_o  (fa_co)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
                    // Subtraction is a + ~b + 1: invert b and preload the carry.
                    b_sh_d  = ld_sub ? ~bus.b : bus.b;
                    carry_d = ld_sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_co;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;
    int   cyc = 0;
    res_t sb[$];

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Results are compared in the cycle they are handed over.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("sum", bus.sum, e.sum);
                check_eq("cout", bus.cout, e.cout);
            end
        end
    end

    task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          output int acc_cyc);
        logic [W:0] r;
        int n;
        res_t e;
        bus.a = x;
        bus.b = y;
`ifdef SERIAL_ADD_CTRL_SUB_EN
        bus.sub = s;
`endif
        bus.in_valid = 1'b1;
        n = 0;
        acc_cyc = -1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 100) begin
                check_eq("accept_timeout", 0, 1);
                return;
            end
        end
        if (s) r = {1'b0, x} + {1'b0, ~y} + 1'b1;
        else   r = {1'b0, x} + {1'b0, y};
        e.sum  = r[W-1:0];
        e.cout = r[W];
        sb.push_back(e);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int c;
        accept(x, y, s, c);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !bus.in_ready) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) check_eq("drain_timeout", 0, 1);
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_in_ready"}, bus.in_ready, 1);
        check_eq({pfx, "_out_valid"}, bus.out_valid, 0);
        check_eq({pfx, "_busy"}, bus.busy, 0);
        check_eq({pfx, "_sum"}, bus.sum, 0);
        check_eq({pfx, "_cout"}, bus.cout, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int busy_cnt, vld_edge, n, prev, c;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
        bus.sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("rst");

        // Latency and busy duration, counting the acceptance edge as edge 1.
        send(8'h5A, 8'h3C, 1'b0);
        busy_cnt = bus.busy ? 1 : 0;
        vld_edge = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busy_cnt++;
            if (bus.out_valid) begin
                vld_edge = e + 1;
                break;
            end
        end
        check_eq("latency_edges", vld_edge, W + 1);
        check_eq("busy_cycles", busy_cnt, W);
        wait_idle();

        send(8'hFF, 8'h01, 1'b0);
        wait_idle();
        send(8'h00, 8'h00, 1'b0);
        wait_idle();

        // Backpressure: result must hold and new operands must be ignored.
        bus.out_ready = 1'b0;
        send(8'hA5, 8'h5A, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("bp_reach_done", bus.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.a = 8'h01;
                bus.b = 8'h01;
                bus.in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            check_eq("bp_out_valid", bus.out_valid, 1);
            check_eq("bp_sum", bus.sum, 8'hFF);
            check_eq("bp_cout", bus.cout, 0);
            check_eq("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_release_in_ready", bus.in_ready, 1);
        check_eq("bp_release_out_valid", bus.out_valid, 0);
        check_eq("bp_sb_empty", sb.size(), 0);

        // Asynchronous reset in the middle of RUN discards the operation.
        send(8'h12, 8'h34, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'h12, 8'h34, 1'b0);
        wait_idle();

        // Back-to-back with in_valid held high: acceptances WIDTH+2 apart.
        prev = -1;
        for (int i = 0; i < 16; i++) begin
            accept(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b0, c);
            if (prev >= 0) check_eq("b2b_spacing", c - prev, W + 2);
            prev = c;
        end
        bus.in_valid = 1'b0;
        wait_idle();

`ifdef SERIAL_ADD_CTRL_SUB_EN
        send(8'h10, 8'h01, 1'b1);
        wait_idle();
        send(8'h01, 8'h02, 1'b1);
        wait_idle();
        bus.sub = 1'b0;
`endif

        check_eq("final_sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
